pc_redirect_ctrl: RTL and testbench

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

---
 rtl/pc_redirect_ctrl_pkg.sv | 13 +
 rtl/pc_redirect_ctrl_redirect_counter.sv | 28 ++
 rtl/pc_redirect_ctrl.sv | 141 ++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared CPU definitions for the PC redirect controller.
// Holds the FSM state encoding and the sequential PC increment.
package pc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_JR_WAIT = 2'd1,
    ST_SQUASH  = 2'd2
  } state_e;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/pc_redirect_ctrl_redirect_counter.sv
// Saturating count of taken redirects.
// Once it reaches all-ones the value holds and never wraps.
module redirect_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;
  logic             w_sat;

  assign w_sat = &r_cnt;
  assign o_cnt = r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && !w_sat) begin
      r_cnt <= r_cnt + ONE;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Next-PC selection and IF/ID, ID/EX flush/stall control for jumps, jr and branches.
// Outputs are combinational from the event inputs; only FSM, squash count and statistics are registered.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      pc_i,
  input  logic             stall_i,
  input  logic             jump_i,
  input  logic [31:0]      jump_target_i,
  input  logic             jr_i,
  input  logic [31:0]      jr_addr_i,
  input  logic             jr_valid_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  output logic [31:0]      pc_next_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  localparam logic [1:0] SQ_LOAD  = 2'(FLUSH_CYCLES - 1);
  localparam state_e     REDIR_ST = (FLUSH_CYCLES == 1) ? ST_RUN : ST_SQUASH;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [1:0]  r_sq_cnt;
  logic [1:0]  w_sq_nxt;
  logic        w_redir;
  logic        w_freeze;
  logic        w_inc;
  logic [31:0] w_target;
  logic [31:0] w_pc_seq;

  assign w_pc_seq = pc_i + PC_INC;

  always_comb begin
    w_state_nxt  = r_state;
    w_sq_nxt     = r_sq_cnt;
    w_redir      = 1'b0;
    w_freeze     = 1'b0;
    w_inc        = 1'b0;
    w_target     = branch_target_i;
    pc_next_o    = w_pc_seq;
    pc_write_o   = 1'b1;
    ifid_write_o = 1'b1;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;

    if (branch_taken_i) begin
      w_redir      = 1'b1;
      idex_flush_o = 1'b1;
    end else if (stall_i) begin
      w_freeze = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          // jr outranks jump, so a decoder raising both is treated as jr
          if (jr_i) begin
            if (jr_valid_i) begin
              w_redir  = 1'b1;
              w_target = jr_addr_i;
            end else begin
              w_freeze    = 1'b1;
              w_state_nxt = ST_JR_WAIT;
            end
          end else if (jump_i) begin
            w_redir  = 1'b1;
            w_target = jump_target_i;
          end
        end
        ST_JR_WAIT: begin
          if (jr_valid_i) begin
            w_redir  = 1'b1;
            w_target = jr_addr_i;
          end else begin
            w_freeze = 1'b1;
          end
        end
        ST_SQUASH: begin
          ifid_flush_o = 1'b1;
          if (r_sq_cnt <= 2'd1) begin
            w_state_nxt = ST_RUN;
            w_sq_nxt    = '0;
          end else begin
            w_sq_nxt = r_sq_cnt - 2'd1;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end

    if (w_redir) begin
      pc_next_o    = w_target;
      ifid_flush_o = 1'b1;
      w_inc        = 1'b1;
      w_state_nxt  = REDIR_ST;
      w_sq_nxt     = SQ_LOAD;
    end

    if (w_freeze) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      idex_flush_o = 1'b1;
    end

    if (!rst_i) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      ifid_flush_o = 1'b0;
      idex_flush_o = 1'b0;
      w_inc        = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= ST_RUN;
      r_sq_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sq_cnt <= w_sq_nxt;
    end
  end

  redirect_counter #(
    .CNT_W (CNT_W)
  ) u_redirect_counter (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_inc   (w_inc),
    .o_cnt   (redirect_cnt_o)
  );

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: three configurations share one stimulus stream and are
// compared every cycle against a priority-rule model, plus hand-computed pins.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        stall, jump, jr, jv, br;
  logic [31:0] jt, ja, bt;

  logic [31:0] o_pcn [3];
  logic        o_pw  [3];
  logic        o_iw  [3];
  logic        o_ifl [3];
  logic        o_idf [3];
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) u0 (
    .clk_i(clk), .rst_i(rst), .pc_i(pc), .stall_i(stall), .jump_i(jump),
    .jump_target_i(jt), .jr_i(jr), .jr_addr_i(ja), .jr_valid_i(jv),
    .branch_taken_i(br), .branch_target_i(bt), .pc_next_o(o_pcn[0]),
    .pc_write_o(o_pw[0]), .ifid_write_o(o_iw[0]), .ifid_flush_o(o_ifl[0]),
    .idex_flush_o(o_idf[0]), .redirect_cnt_o(cnt0));

  pc_redirect_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) u1 (
    .clk_i(clk), .rst_i(rst), .pc_i(pc), .stall_i(stall), .jump_i(jump),
    .jump_target_i(jt), .jr_i(jr), .jr_addr_i(ja), .jr_valid_i(jv),
    .branch_taken_i(br), .branch_target_i(bt), .pc_next_o(o_pcn[1]),
    .pc_write_o(o_pw[1]), .ifid_write_o(o_iw[1]), .ifid_flush_o(o_ifl[1]),
    .idex_flush_o(o_idf[1]), .redirect_cnt_o(cnt1));

  pc_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) u2 (
    .clk_i(clk), .rst_i(rst), .pc_i(pc), .stall_i(stall), .jump_i(jump),
    .jump_target_i(jt), .jr_i(jr), .jr_addr_i(ja), .jr_valid_i(jv),
    .branch_taken_i(br), .branch_target_i(bt), .pc_next_o(o_pcn[2]),
    .pc_write_o(o_pw[2]), .ifid_write_o(o_iw[2]), .ifid_flush_o(o_ifl[2]),
    .idex_flush_o(o_idf[2]), .redirect_cnt_o(cnt2));

  int     f_of [3] = '{1, 3, 1};
  longint cmax [3] = '{65535, 65535, 15};

  // model state: squash cycles still owed, waiting on a jr operand, redirect count
  int  m_sq  [3];
  bit  m_wt  [3];
  int  m_cnt [3];
  int  n_sq  [3];
  bit  n_wt  [3];
  int  n_cnt [3];

  // hand-computed pins per instance: pc_next, pc_write, ifid_write, ifid_flush, idex_flush, count; -1 = unchecked
  longint lit [3][6];
  string  lit_nm [6] = '{"lit_pc_next", "lit_pc_write", "lit_ifid_write",
                         "lit_ifid_flush", "lit_idex_flush", "lit_cnt"};

  int errors = 0;
  int checks = 0;
  bit done   = 1'b0;

  task automatic chk(input string nm, input int k, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[u%0d] got=%0h want=%0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_sq[k] = 0; m_wt[k] = 1'b0; m_cnt[k] = 0;
    end
    forever begin
      @(negedge clk);
      if (done) begin
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
      for (int k = 0; k < 3; k++) begin : per_inst
        longint      act [6];
        logic [31:0] e_pcn, tgt;
        bit          e_pw, e_iw, e_ifl, e_idf, redir;
        act[0] = o_pcn[k];
        act[1] = o_pw[k];
        act[2] = o_iw[k];
        act[3] = o_ifl[k];
        act[4] = o_idf[k];
        act[5] = (k == 0) ? cnt0 : (k == 1) ? cnt1 : cnt2;
        if (!rst) begin
          m_sq[k] = 0; m_wt[k] = 1'b0; m_cnt[k] = 0;
          n_sq[k] = 0; n_wt[k] = 1'b0; n_cnt[k] = 0;
          chk("rst_pc_write", k, act[1], 0);
          chk("rst_ifid_write", k, act[2], 0);
          chk("rst_cnt", k, act[5], 0);
        end else begin
          e_pcn = pc + 32'd4; e_pw = 1; e_iw = 1; e_ifl = 0; e_idf = 0;
          redir = 0; tgt = '0;
          n_sq[k] = m_sq[k]; n_wt[k] = m_wt[k]; n_cnt[k] = m_cnt[k];
          if (br) begin
            redir = 1; tgt = bt; e_idf = 1;
          end else if (stall) begin
            e_pw = 0; e_iw = 0; e_idf = 1;
          end else if (m_sq[k] > 0) begin
            e_ifl = 1; n_sq[k] = m_sq[k] - 1;
          end else if (m_wt[k] || jr) begin
            if (jv) begin
              redir = 1; tgt = ja;
            end else begin
              e_pw = 0; e_iw = 0; e_idf = 1; n_wt[k] = 1;
            end
          end else if (jump) begin
            redir = 1; tgt = jt;
          end
          if (redir) begin
            e_pcn = tgt; e_ifl = 1; n_sq[k] = f_of[k] - 1; n_wt[k] = 0;
            if (m_cnt[k] < cmax[k]) n_cnt[k] = m_cnt[k] + 1;
          end
          if (e_pw) chk("pc_next", k, act[0], e_pcn);
          chk("pc_write", k, act[1], e_pw);
          chk("ifid_write", k, act[2], e_iw);
          chk("ifid_flush", k, act[3], e_ifl);
          chk("idex_flush", k, act[4], e_idf);
          chk("cnt", k, act[5], m_cnt[k]);
        end
        for (int j = 0; j < 6; j++)
          if (lit[k][j] >= 0) chk(lit_nm[j], k, act[j], lit[k][j]);
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        m_sq[k] = n_sq[k]; m_wt[k] = n_wt[k]; m_cnt[k] = n_cnt[k];
      end
    end
  end

  task automatic clr_lit();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 6; j++) lit[k][j] = -1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clr_lit();
  endtask

  task automatic pin(input int k, input longint a, input longint b, input longint c,
                     input longint d, input longint e, input longint f);
    lit[k][0] = a; lit[k][1] = b; lit[k][2] = c;
    lit[k][3] = d; lit[k][4] = e; lit[k][5] = f;
  endtask

  initial begin
    rst = 1'b0; pc = 32'h100;
    stall = 0; jump = 0; jr = 0; jv = 0; br = 0;
    jt = '0; ja = '0; bt = '0;
    clr_lit();
    cyc();
    for (int k = 0; k < 3; k++) pin(k, -1, 0, 0, -1, -1, 0);
    // idle after reset
    cyc(); rst = 1'b1; pin(0, 'h104, 1, 1, 0, 0, 0);
    // single jump; u1 keeps flushing for three cycles in total
    cyc(); jump = 1; jt = 32'h0040_0020;
    pin(0, 'h0040_0020, 1, -1, 1, 0, -1); pin(1, -1, -1, -1, 1, -1, -1);
    cyc(); jump = 0; pin(0, -1, -1, -1, 0, -1, 1); pin(1, 'h104, 1, -1, 1, 0, 1);
    cyc(); pin(1, -1, -1, -1, 1, -1, -1);
    cyc(); pin(1, -1, -1, -1, 0, -1, -1);
    // jump during u1 squash is ignored by u1
    cyc(); jump = 1; jt = 32'h0040_0080; pin(1, 'h0040_0080, -1, -1, 1, -1, 1);
    cyc(); jt = 32'h0040_0040; pin(1, 'h104, 1, -1, 1, -1, -1);
    pin(0, 'h0040_0040, 1, -1, 1, 0, -1);
    cyc(); jump = 0; pin(1, -1, -1, -1, 1, -1, 2);
    cyc(); pin(1, -1, -1, -1, 0, -1, 2);
    // jr with operand not ready for two cycles
    cyc(); jr = 1; jv = 0; pin(0, -1, 0, 0, 0, 1, 3);
    cyc(); pin(0, -1, 0, 0, 0, 1, -1);
    cyc(); jv = 1; ja = 32'h200; pin(0, 'h200, 1, -1, 1, 0, 3);
    cyc(); jr = 0; jv = 0; pin(0, 'h104, 1, 1, 0, 0, 4);
    cyc(); cyc();
    // branch and jump together
    cyc(); br = 1; bt = 32'h300; jump = 1; jt = 32'h400; pin(0, 'h300, 1, -1, 1, 1, 4);
    cyc(); br = 0; jump = 0; pin(0, -1, -1, -1, 0, 0, 5);
    cyc(); cyc();
    // branch abandons a pending jr
    cyc(); jr = 1; jv = 0; pin(0, -1, 0, 0, -1, 1, -1);
    cyc(); br = 1; bt = 32'h500; pin(0, 'h500, 1, -1, 1, 1, -1);
    cyc(); br = 0; jr = 0; pin(0, 'h104, 1, 1, 0, 0, 6);
    cyc(); cyc();
    // stall beats jump; jump+jr acts as jr
    cyc(); stall = 1; pin(0, -1, 0, 0, 0, 1, -1);
    cyc(); jump = 1; jt = 32'h700; pin(0, -1, 0, 0, 0, 1, 6);
    cyc(); stall = 0; jr = 1; jv = 1; ja = 32'h600; pin(0, 'h600, 1, -1, 1, 0, 6);
    cyc(); jump = 0; jr = 0; jv = 0; pin(0, -1, -1, -1, -1, -1, 7);
    cyc(); cyc();
    // saturate the 4-bit counter
    repeat (20) begin
      cyc(); jump = 1; jt = 32'h800;
    end
    cyc(); jump = 0;
    cyc(); cyc();
    cyc(); pin(2, -1, -1, -1, -1, -1, 15);
    // reset while waiting on jr
    cyc(); jr = 1; jv = 0; pin(0, -1, 0, 0, -1, 1, -1);
    cyc(); rst = 1'b0;
    for (int k = 0; k < 3; k++) pin(k, -1, 0, 0, -1, -1, 0);
    cyc(); rst = 1'b1; jr = 0; jv = 1; ja = 32'h900;
    pin(0, 'h104, 1, 1, 0, 0, 0); pin(2, 'h104, 1, 1, 0, 0, 0);
    cyc(); jv = 0;
    cyc(); done = 1'b1;
  end

endmodule
